regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_pkg.sv | 19 +
 rtl/regfile_scoreboard_popcount.sv | 25 ++
 rtl/regfile_scoreboard.sv | 130 +++++++++++++
 tb/tb_regfile_scoreboard.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_pkg
//  Description : Shared constants for the register-file scoreboard: default
//                data and address widths and the register-count derivation.
//  Revision    : 1.0 - initial release
// ============================================================================
package regfile_scoreboard_pkg;

    localparam int DEFAULT_DATA_W = 9;
    localparam int DEFAULT_ADDR_W = 2;

    // Number of architectural registers addressed by an addr_w-bit index.
    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : regfile_scoreboard_pkg
`default_nettype wire

// File: rtl/regfile_scoreboard_popcount.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_popcount
//  Description : Parametrised combinational population counter.
//  Ports       : bits  (in,  N) - vector to count
//                count (out, W) - number of set bits in 'bits'
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_popcount #(
    parameter int N = 4,
    parameter int W = 3
) (
    input  logic [N-1:0] bits,
    output logic [W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(bits[i]);
        end
    end

endmodule : regfile_popcount
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Two-read / one-write register file with a per-register
//                busy scoreboard for destination reservation (issue) and
//                release (writeback).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rd0_addr/rd1_addr   - read addresses
//                rd0_data/rd1_data   - combinational read data
//                rd0_busy/rd1_busy   - pending-producer flag of read register
//                wr_en/wr_addr/wr_data - writeback (writes data, clears busy)
//                iss_en/iss_addr     - reservation request
//                iss_ok              - reservation of iss_addr is acceptable
//                busy_vec/busy_cnt   - busy bits and their registered count
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDR_W-1:0]        rd0_addr,
    input  logic [ADDR_W-1:0]        rd1_addr,
    output logic [DATA_W-1:0]        rd0_data,
    output logic [DATA_W-1:0]        rd1_data,
    output logic                     rd0_busy,
    output logic                     rd1_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_ok,
    output logic [nregs(ADDR_W)-1:0] busy_vec,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int NREGS = nregs(ADDR_W);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic [NREGS-1:0]  r_busy;
    logic [ADDR_W:0]   r_busy_cnt;

    logic              w_wr_zero;
    logic              w_iss_zero;
    logic              w_wr_eff;
    logic              w_iss_eff;
    logic [NREGS-1:0]  w_busy_nxt;
    logic [ADDR_W:0]   w_cnt_nxt;

    // Register 0 is inert when hardwired: writes dropped, never reserved.
    assign w_wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_iss_zero = (ZERO_REG != 0) && (iss_addr == '0);
    assign w_wr_eff   = wr_en && !w_wr_zero;

    // A writeback landing this cycle frees the register for a new producer.
    assign iss_ok    = !r_busy[iss_addr] || (wr_en && (wr_addr == iss_addr));
    assign w_iss_eff = iss_en && iss_ok && !w_iss_zero;

    // Set after clear: a same-cycle issue to the written register keeps it
    // reserved for the new producer.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_wr_eff) begin
            w_busy_nxt[wr_addr] = 1'b0;
        end
        if (w_iss_eff) begin
            w_busy_nxt[iss_addr] = 1'b1;
        end
    end

    // Count the next-state vector so the registered count tracks busy_vec.
    regfile_popcount #(
        .N (NREGS),
        .W (ADDR_W + 1)
    ) u_popcount (
        .bits  (w_busy_nxt),
        .count (w_cnt_nxt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            if (w_wr_eff) begin
                r_regs[wr_addr] <= wr_data;
            end
            r_busy     <= w_busy_nxt;
            r_busy_cnt <= w_cnt_nxt;
        end
    end

    // Read ports: zero register first, then same-cycle forwarding, then array.
    logic [ADDR_W-1:0] w_rd_addr [2];
    logic [DATA_W-1:0] w_rd_data [2];
    logic              w_rd_busy [2];

    assign w_rd_addr[0] = rd0_addr;
    assign w_rd_addr[1] = rd1_addr;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd
            logic w_hit;
            logic w_zero;
            assign w_hit  = (BYPASS != 0) && wr_en && (wr_addr == w_rd_addr[p]);
            assign w_zero = (ZERO_REG != 0) && (w_rd_addr[p] == '0);
            assign w_rd_data[p] = w_zero ? '0 :
                                  w_hit  ? wr_data : r_regs[w_rd_addr[p]];
            assign w_rd_busy[p] = r_busy[w_rd_addr[p]] && !w_hit;
        end
    endgenerate

    assign rd0_data = w_rd_data[0];
    assign rd1_data = w_rd_data[1];
    assign rd0_busy = w_rd_busy[0];
    assign rd1_busy = w_rd_busy[1];
    assign busy_vec = r_busy;
    assign busy_cnt = r_busy_cnt;

endmodule : regfile_scoreboard
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Self-checking bench for regfile_scoreboard. Two instances
//                share the stimulus: index 0 uses defaults (BYPASS=1,
//                ZERO_REG=0), index 1 uses ZERO_REG=1, BYPASS=0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] rd0_addr, rd1_addr, wr_addr, iss_addr;
    logic       wr_en, iss_en;
    logic [8:0] wr_data;

    logic [8:0] rd0_data_a, rd1_data_a, rd0_data_z, rd1_data_z;
    logic       rd0_busy_a, rd1_busy_a, rd0_busy_z, rd1_busy_z;
    logic       iss_ok_a, iss_ok_z;
    logic [3:0] busy_vec_a, busy_vec_z;
    logic [2:0] busy_cnt_a, busy_cnt_z;

    always #5 clk = ~clk;

    regfile_scoreboard dut_a (
        .clk(clk), .rst(rst),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(rd0_data_a), .rd1_data(rd1_data_a),
        .rd0_busy(rd0_busy_a), .rd1_busy(rd1_busy_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok_a),
        .busy_vec(busy_vec_a), .busy_cnt(busy_cnt_a)
    );

    regfile_scoreboard #(.ZERO_REG(1), .BYPASS(0)) dut_z (
        .clk(clk), .rst(rst),
        .rd0_addr(rd0_addr), .rd1_addr(rd1_addr),
        .rd0_data(rd0_data_z), .rd1_data(rd1_data_z),
        .rd0_busy(rd0_busy_z), .rd1_busy(rd1_busy_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok_z),
        .busy_vec(busy_vec_z), .busy_cnt(busy_cnt_z)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: architectural register values and pending flags.
    logic [8:0] m_regs [2][4];
    logic       m_busy [2][4];
    bit         m_zr   [2] = '{1'b0, 1'b1};
    bit         m_by   [2] = '{1'b1, 1'b0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] exp_rd(input int k, input logic [1:0] a);
        if (m_zr[k] && a == 2'd0) return 9'd0;
        if (m_by[k] && wr_en && wr_addr == a) return wr_data;
        return m_regs[k][a];
    endfunction

    function automatic logic exp_rbusy(input int k, input logic [1:0] a);
        return m_busy[k][a] && !(m_by[k] && wr_en && wr_addr == a);
    endfunction

    function automatic logic exp_ok(input int k);
        return !m_busy[k][iss_addr] || (wr_en && wr_addr == iss_addr);
    endfunction

    function automatic logic [3:0] exp_vec(input int k);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = m_busy[k][i];
        return v;
    endfunction

    function automatic logic [2:0] exp_cnt(input int k);
        int c = 0;
        for (int i = 0; i < 4; i++) if (m_busy[k][i]) c++;
        return 3'(c);
    endfunction

    task automatic check_inst(input int k, input logic [8:0] d0, input logic [8:0] d1,
                              input logic b0, input logic b1, input logic ok,
                              input logic [3:0] vec, input logic [2:0] cnt);
        string s = (k == 0) ? "byp" : "zr";
        check({s, "_rd0_data"}, d0, exp_rd(k, rd0_addr));
        check({s, "_rd1_data"}, d1, exp_rd(k, rd1_addr));
        check({s, "_rd0_busy"}, b0, exp_rbusy(k, rd0_addr));
        check({s, "_rd1_busy"}, b1, exp_rbusy(k, rd1_addr));
        check({s, "_iss_ok"},   ok, exp_ok(k));
        check({s, "_busy_vec"}, vec, exp_vec(k));
        check({s, "_busy_cnt"}, cnt, exp_cnt(k));
    endtask

    // Apply inputs mid-cycle and compare combinational/registered outputs.
    task automatic drive(input logic r, input logic we, input logic [1:0] wa,
                         input logic [8:0] wd, input logic ie, input logic [1:0] ia,
                         input logic [1:0] ra0, input logic [1:0] ra1);
        @(negedge clk);
        rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
        iss_en = ie; iss_addr = ia; rd0_addr = ra0; rd1_addr = ra1;
        #1;
        if (!r) begin
            check_inst(0, rd0_data_a, rd1_data_a, rd0_busy_a, rd1_busy_a,
                       iss_ok_a, busy_vec_a, busy_cnt_a);
            check_inst(1, rd0_data_z, rd1_data_z, rd0_busy_z, rd1_busy_z,
                       iss_ok_z, busy_vec_z, busy_cnt_z);
        end
    endtask

    // Advance through the clock edge and apply the same rules to the model.
    task automatic commit();
        bit acc [2];
        for (int k = 0; k < 2; k++) acc[k] = iss_en && exp_ok(k) && !(m_zr[k] && iss_addr == 2'd0);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    m_regs[k][i] = 9'd0;
                    m_busy[k][i] = 1'b0;
                end
            end else begin
                if (wr_en && !(m_zr[k] && wr_addr == 2'd0)) begin
                    m_regs[k][wr_addr] = wr_data;
                    m_busy[k][wr_addr] = 1'b0;
                end
                if (acc[k]) m_busy[k][iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic r, input logic we, input logic [1:0] wa,
                        input logic [8:0] wd, input logic ie, input logic [1:0] ia,
                        input logic [1:0] ra0, input logic [1:0] ra1);
        drive(r, we, wa, wd, ie, ia, ra0, ra1);
        commit();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; iss_en = 1'b0;
        wr_addr = '0; iss_addr = '0; wr_data = '0; rd0_addr = '0; rd1_addr = '0;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 4; i++) begin
                m_regs[k][i] = 'x;
                m_busy[k][i] = 1'b0;
            end

        // Reset, then read every address.
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 2, 3);
        #1;
        check("rst_busy_vec", busy_vec_a, 4'h0);
        check("rst_busy_cnt", busy_cnt_a, 3'd0);
        check("rst_iss_ok",   iss_ok_a,   1'b1);
        check("rst_rd1_data", rd1_data_a, 9'h000);

        // Write r2 while reading r2.
        drive(0, 1, 2, 9'h1A5, 0, 0, 2, 2);
        check("byp_same_cycle", rd0_data_a, 9'h1A5);
        check("nobyp_old_val",  rd0_data_z, 9'h000);
        commit();
        drive(0, 0, 0, 0, 0, 0, 2, 0);
        check("nobyp_next_cycle", rd0_data_z, 9'h1A5);
        commit();

        // Issue r1 twice, then release with a writeback.
        step(0, 0, 0, 0, 1, 1, 1, 0);
        drive(0, 0, 0, 0, 1, 1, 1, 0);
        check("waw_iss_ok", iss_ok_a, 1'b0);
        commit();
        #1 check("waw_busy_cnt", busy_cnt_a, 3'd1);
        step(0, 1, 1, 9'h003, 0, 0, 1, 0);
        #1;
        check("rel_busy1", busy_vec_a[1], 1'b0);
        check("rel_cnt",   busy_cnt_a,    3'd0);

        // Same-cycle issue and write to r3.
        step(0, 1, 3, 9'h0FF, 1, 3, 0, 0);
        #1;
        check("iw_busy3", busy_vec_a[3], 1'b1);
        check("iw_cnt",   busy_cnt_a,    3'd1);
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        check("iw_reg3",  rd0_data_a, 9'h0FF);
        commit();

        // Hardwired zero register.
        drive(0, 1, 0, 9'h1FF, 1, 0, 0, 0);
        check("zr_iss_ok", iss_ok_z,   1'b1);
        check("zr_rd0",    rd0_data_z, 9'h000);
        commit();
        #1;
        check("zr_busy0",  busy_vec_z[0], 1'b0);
        check("zr_rd_after", rd0_data_z,  9'h000);

        // Reservations discarded by reset, reset overrides a write.
        step(0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 1, 3, 0, 0);
        step(1, 1, 1, 9'h155, 1, 0, 0, 0);
        #1;
        check("mid_rst_vec", busy_vec_a, 4'h0);
        check("mid_rst_cnt", busy_cnt_a, 3'd0);
        drive(0, 0, 0, 0, 0, 0, 1, 1);
        check("mid_rst_r1", rd0_data_a, 9'h000);
        commit();
        step(0, 1, 2, 9'h0AA, 0, 0, 2, 3);

        // Randomized traffic.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 39) == 0), 1'($urandom), 2'($urandom), 9'($urandom),
                 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_regfile_scoreboard
`default_nettype wire
